quad_enc_gen: RTL and testbench

QUAD_ENC_GEN -- requirements
Module: quad_enc_gen

---
 rtl/quad_enc_pkg.sv | 18 +
 rtl/enc_phase_out.sv | 26 ++
 rtl/quad_enc_gen.sv | 154 +++++++++++++++
 tb/tb_quad_enc_gen.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/quad_enc_pkg.sv
// Shared definitions for the quadrature encoder generator.
//   enc_state_e : sequencing states (IDLE waits for a command, WAIT counts the
//                 inter-edge period, STEP applies one count).
//   phase_to_ab : maps the two low position bits to the {A,B} pair.
package quad_enc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_STEP = 2'd2
    } enc_state_e;

    // Forward sequence of p = 0,1,2,3 gives (A,B) = 00,10,11,01, so A leads B.
    function automatic logic [1:0] phase_to_ab(input logic [1:0] p);
        return {p[1] ^ p[0], p[1]};
    endfunction

endpackage

// File: rtl/enc_phase_out.sv
// Registered encoder output stage.
//   clk      : system clock
//   reset    : asynchronous active-high reset (outputs 3'b001, i.e. position 0)
//   pos_next : position value that the position register loads on this edge
//   enc_abz  : registered {A, B, Z}
// Fed from the next-position value so that enc_abz changes on the same edge
// as the position register.
module enc_phase_out
    import quad_enc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] pos_next,
    output logic [2:0]  enc_abz
);

    // Phase/index register: A/B from the low position bits, Z while at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enc_abz <= 3'b001;
        end else begin
            enc_abz <= {phase_to_ab(pos_next[1:0]), (pos_next == 16'd0)};
        end
    end

endmodule

// File: rtl/quad_enc_gen.sv
// Quadrature encoder signal generator.
//   clk        : system clock, rising edge
//   reset      : asynchronous active-high reset
//   cmd_valid  : command offered
//   cmd_ready  : command can be accepted (IDLE and no abort)
//   cmd_steps  : signed count delta, positive = forward
//   cmd_period : clocks per count edge (clamped to MIN_PERIOD)
//   abort      : synchronous stop request
//   enc_abz    : registered {A, B, Z}
//   position   : registered count, 0..COUNTS_PER_REV-1
//   busy       : registered, high while a command is in progress
//   done       : registered one-cycle pulse on normal completion
module quad_enc_gen
    import quad_enc_pkg::*;
#(
    parameter int COUNTS_PER_REV = 2048,
    parameter int MIN_PERIOD     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_steps,
    input  logic [15:0] cmd_period,
    input  logic        abort,
    output logic [2:0]  enc_abz,
    output logic [15:0] position,
    output logic        busy,
    output logic        done
);

    localparam logic [15:0] POS_MAX = 16'(COUNTS_PER_REV - 1);
    localparam logic [15:0] MIN_P   = 16'(MIN_PERIOD);

    enc_state_e  state_r, state_nxt_s;
    logic [15:0] cnt_r, cnt_nxt_s;
    logic [15:0] mag_r, mag_nxt_s;
    logic [15:0] period_r, period_nxt_s;
    logic        dir_r, dir_nxt_s;
    logic [15:0] position_r, pos_nxt_s;
    logic        busy_r, done_r, done_nxt_s;
    logic [15:0] period_clamp_s;
    logic [15:0] steps_mag_s;

    // One count in the requested direction with wrap at the revolution ends.
    function automatic logic [15:0] step_pos(input logic [15:0] p, input logic rev);
        if (rev) begin
            return (p == 16'd0) ? POS_MAX : (p - 16'd1);
        end else begin
            return (p == POS_MAX) ? 16'd0 : (p + 16'd1);
        end
    endfunction

    assign cmd_ready = (state_r == ST_IDLE) && !abort;
    assign position  = position_r;
    assign busy      = busy_r;
    assign done      = done_r;

    // Command decode: clamped period and 16-bit unsigned magnitude
    // (-32768 yields 32768 since 16'd0 - 16'h8000 == 16'h8000).
    always_comb begin
        period_clamp_s = (cmd_period < MIN_P) ? MIN_P : cmd_period;
        steps_mag_s    = cmd_steps[15] ? (16'd0 - cmd_steps) : cmd_steps;
    end

    // Next-state and datapath decisions.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        mag_nxt_s    = mag_r;
        period_nxt_s = period_r;
        dir_nxt_s    = dir_r;
        pos_nxt_s    = position_r;
        done_nxt_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    period_nxt_s = period_clamp_s;
                    mag_nxt_s    = steps_mag_s;
                    dir_nxt_s    = cmd_steps[15];
                    if (steps_mag_s == 16'd0) begin
                        done_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_WAIT;
                        cnt_nxt_s   = period_clamp_s;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (abort) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    cnt_nxt_s = cnt_r - 16'd1;
                    // Leaving at count 2 -> 1 puts the edge P clocks after load.
                    if (cnt_r <= 16'd2) begin
                        state_nxt_s = ST_STEP;
                    end else begin
                        state_nxt_s = ST_WAIT;
                    end
                end
            end
            ST_STEP: begin
                // The count is applied even when abort coincides.
                pos_nxt_s = step_pos(position_r, dir_r);
                mag_nxt_s = mag_r - 16'd1;
                if (abort) begin
                    state_nxt_s = ST_IDLE;
                end else if (mag_r == 16'd1) begin
                    state_nxt_s = ST_IDLE;
                    done_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_WAIT;
                    cnt_nxt_s   = period_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 16'd0;
            mag_r      <= 16'd0;
            period_r   <= 16'd0;
            dir_r      <= 1'b0;
            position_r <= 16'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            mag_r      <= mag_nxt_s;
            period_r   <= period_nxt_s;
            dir_r      <= dir_nxt_s;
            position_r <= pos_nxt_s;
            busy_r     <= (state_nxt_s != ST_IDLE);
            done_r     <= done_nxt_s;
        end
    end

    enc_phase_out u_phase (
        .clk      (clk),
        .reset    (reset),
        .pos_next (pos_nxt_s),
        .enc_abz  (enc_abz)
    );

endmodule

// File: tb/tb_quad_enc_gen.sv
// Directed self-checking bench for quad_enc_gen (COUNTS_PER_REV=2048).
module tb_quad_enc_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_steps = 16'd0;
    logic [15:0] cmd_period = 16'd0;
    logic        abort = 1'b0;
    logic [2:0]  enc_abz;
    logic [15:0] position;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_mis = 0;
    logic [1:0] ab_q[$];

    quad_enc_gen #(.COUNTS_PER_REV(2048), .MIN_PERIOD(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_steps  (cmd_steps),
        .cmd_period (cmd_period),
        .abort      (abort),
        .enc_abz    (enc_abz),
        .position   (position),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic int wrap(input int p);
        return ((p % 2048) + 2048) % 2048;
    endfunction

    function automatic logic [2:0] exp_abz(input int p);
        logic [10:0] v;
        v = 11'(p);
        return {v[1] ^ v[0], v[1], (p == 0)};
    endfunction

    // Offer a command for exactly one edge; returns at the negedge after acceptance.
    task automatic send_cmd(input logic [15:0] s, input logic [15:0] p);
        @(negedge clk);
        chk("ready_before_cmd", cmd_ready, 1'b1);
        cmd_valid  = 1'b1;
        cmd_steps  = s;
        cmd_period = p;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Check cycles k0..k1 after acceptance against expected edge timing.
    task automatic run_check(input int start, input int dir, input int per,
                             input int n, input int k0, input int k1);
        int cnt;
        int ep;
        for (int k = k0; k <= k1; k++) begin
            @(negedge clk);
            cnt = k / per;
            if (cnt > n) cnt = n;
            ep = wrap(start + dir * cnt);
            chk("position", position, ep);
            chk("enc_abz", enc_abz, exp_abz(ep));
            chk("busy", busy, (cnt < n));
            chk("done", done, (k == per * n));
            if ((k % per == 0) && (k / per <= n)) ab_q.push_back(enc_abz[2:1]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded its time limit");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_abz", enc_abz, 3'b001);
        chk("rst_pos", position, 16'd0);
        chk("rst_ready", cmd_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);

        // +5 steps, period 4: edges at 4,8,...,20, AB 10,11,01,00,10
        ab_q.delete();
        send_cmd(16'd5, 16'd4);
        run_check(0, 1, 4, 5, 1, 22);
        chk("fwd5_nedges", ab_q.size(), 5);
        if (ab_q.size() == 5) begin
            chk("fwd5_ab0", ab_q[0], 2'b10);
            chk("fwd5_ab1", ab_q[1], 2'b11);
            chk("fwd5_ab2", ab_q[2], 2'b01);
            chk("fwd5_ab3", ab_q[3], 2'b00);
            chk("fwd5_ab4", ab_q[4], 2'b10);
        end
        chk("fwd5_pos", position, 16'd5);

        // Move back to position 1
        send_cmd(-16'sd4, 16'd2);
        run_check(5, -1, 2, 4, 1, 9);

        // -3 steps from 1, period 2: 0, 2047, 2046; AB 00,01,11
        ab_q.delete();
        send_cmd(-16'sd3, 16'd2);
        run_check(1, -1, 2, 3, 1, 7);
        chk("rev3_nedges", ab_q.size(), 3);
        if (ab_q.size() == 3) begin
            chk("rev3_ab0", ab_q[0], 2'b00);
            chk("rev3_ab1", ab_q[1], 2'b01);
            chk("rev3_ab2", ab_q[2], 2'b11);
        end
        chk("rev3_pos", position, 16'd2046);

        // +4 steps, period 0 clamped to 2, forward wrap through 0
        send_cmd(16'd4, 16'd0);
        run_check(2046, 1, 2, 4, 1, 9);
        chk("clamp_pos", position, 16'd2);

        // +100 steps, period 10, abort seen at edge 35 -> 3 counts, no done
        send_cmd(16'd100, 16'd10);
        run_check(2, 1, 10, 100, 1, 34);
        abort = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_pos", position, 16'd5);
        chk("abort_abz", enc_abz, exp_abz(5));
        chk("abort_ready_blocked", cmd_ready, 1'b0);
        abort = 1'b0;
        #1;
        chk("abort_ready_after", cmd_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_hold_pos", position, 16'd5);
            chk("abort_hold_done", done, 1'b0);
            chk("abort_hold_abz", enc_abz, exp_abz(5));
        end

        // steps=0: done on the next cycle, no edge
        send_cmd(16'd0, 16'd3);
        chk("zero_done", done, 1'b1);
        chk("zero_busy", busy, 1'b0);
        chk("zero_pos", position, 16'd5);
        @(negedge clk);
        chk("zero_done_off", done, 1'b0);
        chk("zero_pos2", position, 16'd5);

        // abort in IDLE blocks acceptance
        abort      = 1'b1;
        cmd_valid  = 1'b1;
        cmd_steps  = 16'd7;
        cmd_period = 16'd2;
        #1;
        chk("idle_abort_ready", cmd_ready, 1'b0);
        repeat (4) @(negedge clk);
        chk("idle_abort_busy", busy, 1'b0);
        chk("idle_abort_pos", position, 16'd5);
        cmd_valid = 1'b0;
        abort     = 1'b0;

        // cmd_valid while busy is ignored
        send_cmd(16'd2, 16'd3);
        cmd_valid = 1'b1;
        cmd_steps = 16'd50;
        run_check(5, 1, 3, 2, 1, 4);
        cmd_valid = 1'b0;
        run_check(5, 1, 3, 2, 5, 10);
        chk("ignore_pos", position, 16'd7);

        // -32768: reverse direction with a large magnitude, then abort
        send_cmd(16'h8000, 16'd2);
        run_check(7, -1, 2, 32768, 1, 10);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("minneg_busy", busy, 1'b0);
        chk("minneg_pos", position, 16'd2);

        // Reset mid-command discards it immediately
        send_cmd(16'd10, 16'd2);
        run_check(2, 1, 2, 10, 1, 5);
        reset = 1'b1;
        #1;
        chk("midrst_pos", position, 16'd0);
        chk("midrst_abz", enc_abz, 3'b001);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("postrst_ready", cmd_ready, 1'b1);
        chk("postrst_pos", position, 16'd0);
        chk("postrst_done", done, 1'b0);
        chk("postrst_busy", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
